// File: rtl/wb_dma_ch_sched_pkg.sv
// -----------------------------------------------------------------------------
// wb_dma_ch_sched_pkg
// Shared definitions for the DMA channel scheduler:
//   - sched_state_t : 2-bit scheduler state encoding (IDLE/ARB/START/BUSY)
//   - WDMA_PRI_LSB/MSB : location of the 3-bit priority field inside a CSR
//   - CH_SEL_W : width of the channel-select bus
// No ports (package).
// -----------------------------------------------------------------------------
package wb_dma_ch_sched_pkg;

    typedef enum logic [1:0] {
        WDMA_SCHED_IDLE  = 2'd0,
        WDMA_SCHED_ARB   = 2'd1,
        WDMA_SCHED_START = 2'd2,
        WDMA_SCHED_BUSY  = 2'd3
    } sched_state_t;

    localparam int WDMA_PRI_LSB = 13;
    localparam int WDMA_PRI_MSB = 15;
    localparam int CH_SEL_W     = 5;

endpackage

// File: rtl/wb_dma_rr_pick.sv
// -----------------------------------------------------------------------------
// wb_dma_rr_pick
// Combinational round-robin picker. Returns the first set bit of the
// candidate mask searching upward from i_last+1, wrapping at CH_COUNT-1.
// Ports:
//   i_cand  [CH_COUNT-1:0]  candidate mask (already priority-filtered)
//   i_last  [4:0]           channel served most recently
//   o_pick  [4:0]           chosen channel (0 when the mask is empty)
// -----------------------------------------------------------------------------
module wb_dma_rr_pick
    import wb_dma_ch_sched_pkg::*;
#(
    parameter int CH_COUNT = 8
) (
    input  logic [CH_COUNT-1:0] i_cand,
    input  logic [CH_SEL_W-1:0] i_last,
    output logic [CH_SEL_W-1:0] o_pick
);

    logic [2*CH_COUNT-1:0] w_dbl;
    logic [CH_COUNT-1:0]   w_rot;
    logic [CH_SEL_W:0]     w_shift;

    // Doubling the mask turns the wrap-around search into a plain right shift:
    // bit j of w_rot is candidate (i_last+1+j) mod CH_COUNT.
    assign w_dbl   = {i_cand, i_cand};
    assign w_shift = {1'b0, i_last} + 6'd1;
    assign w_rot   = CH_COUNT'(w_dbl >> w_shift);

    always_comb begin
        logic v_found;
        int   v_sum;
        v_found = 1'b0;
        v_sum   = 0;
        o_pick  = '0;
        for (int j = 0; j < CH_COUNT; j++) begin
            if (!v_found && w_rot[j]) begin
                v_found = 1'b1;
                v_sum   = int'(i_last) + 1 + j;
                if (v_sum >= CH_COUNT) begin
                    v_sum = v_sum - CH_COUNT;
                end
                o_pick = CH_SEL_W'(v_sum);
            end
        end
    end

endmodule

// File: rtl/wb_dma_ch_sched.sv
// -----------------------------------------------------------------------------
// wb_dma_ch_sched
// DMA channel scheduler. Qualifies requests with enables, picks the highest
// priority requester (round-robin among equals), issues a one-cycle start
// pulse and holds the grant until the engine signals done/done_all/err.
// Ports:
//   i_clk, i_rst (sync, active-low)
//   i_ch_req, i_ch_en [CH_COUNT]   per-channel request / enable
//   i_ch_pri [PRI_W*CH_COUNT]      packed priorities, ch i at [PRI_W*i +: PRI_W]
//   i_pause                        blocks new grants (checked in IDLE only)
//   i_dma_busy                     engine busy, blocks new grants
//   i_dma_done/_done_all/_err      grant terminators (only honoured in BUSY)
//   o_ch_sel [5]                   selected channel
//   o_ch_sel_vld                   o_ch_sel owns the engine
//   o_de_start                     one-cycle start pulse
//   o_sched_idle                   scheduler is idle
// -----------------------------------------------------------------------------
module wb_dma_ch_sched
    import wb_dma_ch_sched_pkg::*;
#(
    parameter int CH_COUNT = 8,
    parameter int PRI_W    = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CH_COUNT-1:0]       i_ch_req,
    input  logic [CH_COUNT-1:0]       i_ch_en,
    input  logic [PRI_W*CH_COUNT-1:0] i_ch_pri,
    input  logic                      i_pause,
    input  logic                      i_dma_busy,
    input  logic                      i_dma_done,
    input  logic                      i_dma_done_all,
    input  logic                      i_dma_err,
    output logic [CH_SEL_W-1:0]       o_ch_sel,
    output logic                      o_ch_sel_vld,
    output logic                      o_de_start,
    output logic                      o_sched_idle
);

    sched_state_t        r_state;
    sched_state_t        w_next;
    logic [CH_SEL_W-1:0] r_ch_sel;
    logic [CH_SEL_W-1:0] r_last_ch;
    logic                r_ch_sel_vld;
    logic                r_de_start;

    logic [CH_COUNT-1:0] w_vreq;
    logic [CH_COUNT-1:0] w_cand;
    logic [PRI_W-1:0]    w_maxp;
    logic [CH_SEL_W-1:0] w_pick;
    logic                w_term;

    assign w_vreq = i_ch_req & i_ch_en;
    // Coincident terminators collapse into a single release.
    assign w_term = i_dma_done | i_dma_done_all | i_dma_err;

    always_comb begin
        w_maxp = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            if (w_vreq[i] && (i_ch_pri[PRI_W*i +: PRI_W] > w_maxp)) begin
                w_maxp = i_ch_pri[PRI_W*i +: PRI_W];
            end
        end
    end

    always_comb begin
        w_cand = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            w_cand[i] = w_vreq[i] && (i_ch_pri[PRI_W*i +: PRI_W] == w_maxp);
        end
    end

    wb_dma_rr_pick #(
        .CH_COUNT (CH_COUNT)
    ) u_rr_pick (
        .i_cand (w_cand),
        .i_last (r_last_ch),
        .o_pick (w_pick)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            WDMA_SCHED_IDLE: begin
                if ((|w_vreq) && !i_pause && !i_dma_busy) begin
                    w_next = WDMA_SCHED_ARB;
                end
            end
            WDMA_SCHED_ARB: begin
                // Request may be withdrawn in the arbitration cycle.
                w_next = (|w_vreq) ? WDMA_SCHED_START : WDMA_SCHED_IDLE;
            end
            WDMA_SCHED_START: begin
                w_next = WDMA_SCHED_BUSY;
            end
            WDMA_SCHED_BUSY: begin
                if (w_term) begin
                    w_next = WDMA_SCHED_IDLE;
                end
            end
            default: w_next = WDMA_SCHED_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= WDMA_SCHED_IDLE;
            r_ch_sel     <= '0;
            r_ch_sel_vld <= 1'b0;
            r_de_start   <= 1'b0;
            r_last_ch    <= CH_SEL_W'(CH_COUNT - 1);
        end else begin
            r_state    <= w_next;
            // High exactly while the state register holds START.
            r_de_start <= (r_state == WDMA_SCHED_ARB) && (|w_vreq);
            if ((r_state == WDMA_SCHED_ARB) && (|w_vreq)) begin
                r_ch_sel     <= w_pick;
                r_ch_sel_vld <= 1'b1;
            end
            // ch_sel is kept after release for register-file write-back.
            if ((r_state == WDMA_SCHED_BUSY) && w_term) begin
                r_last_ch    <= r_ch_sel;
                r_ch_sel_vld <= 1'b0;
            end
        end
    end

    assign o_ch_sel     = r_ch_sel;
    assign o_ch_sel_vld = r_ch_sel_vld;
    assign o_de_start   = r_de_start;
    assign o_sched_idle = (r_state == WDMA_SCHED_IDLE);

endmodule

// File: doc/wb_dma_ch_sched.md
Name: wb_dma_ch_sched

Overview:
- Channel scheduler for the DMA engine.
- Each cycle it samples every channel's request qualified by its enable bit, then picks one channel: highest 3-bit CSR priority first, round-robin among channels of equal priority.
- It drives ch_sel to the per-channel register files and the engine, and hands the engine a one-cycle start pulse.
- It holds the grant until the engine reports end of chunk, end of transfer or error.

Parameters:
- CH_COUNT, 8, number of channels (1..31); channel i maps to ch_sel value i.
- PRI_W, 3, priority field width per channel (matches CSR bits [15:13]).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- ch_req  in  CH_COUNT  per-channel transfer request (HW handshake or SW-start pending)
- ch_en  in  CH_COUNT  per-channel enable (CSR enable bit already gated by ch_dis)
- ch_pri  in  PRI_W*CH_COUNT  packed priorities; channel i uses bits [PRI_W*i +: PRI_W]
- pause  in  1  global pause; blocks new grants only
- dma_busy  in  1  engine busy
- dma_done  in  1  chunk done pulse
- dma_done_all  in  1  transfer done pulse
- dma_err  in  1  error pulse
- ch_sel  out  5  selected channel number
- ch_sel_vld  out  1  ch_sel owns the engine
- de_start  out  1  one-cycle start pulse to the engine
- sched_idle  out  1  high in state IDLE

Behaviour:
- Reset: all registered on posedge clk; rst low at any edge forces the following values, including mid-transfer.
  - state = IDLE; ch_sel = 0; ch_sel_vld = 0; de_start = 0; last_ch = CH_COUNT-1.
  - The first round-robin search therefore starts at channel 0.
- Qualified request: vreq = ch_req & ch_en.
- States: IDLE, ARB, START, BUSY.
- IDLE:
  - If |vreq and !pause and !dma_busy, go to ARB.
  - Otherwise stay in IDLE.
- ARB (one cycle):
  - Compute maxp = the largest ch_pri over the set bits of vreq.
  - Candidate set = vreq bits whose priority equals maxp.
  - Pick the first candidate searching upward from last_ch+1, wrapping at CH_COUNT-1 to 0.
  - Register the pick into ch_sel, set ch_sel_vld = 1, go to START.
  - If vreq is 0 in the ARB cycle (request withdrawn), return to IDLE; ch_sel_vld stays 0.
- START:
  - de_start = 1 for exactly this one cycle; go to BUSY.
  - If vreq[ch_sel] dropped during START, the pulse is still issued; the engine owns the abort.
- BUSY:
  - Hold ch_sel and ch_sel_vld stable.
  - On dma_done | dma_done_all | dma_err: last_ch = ch_sel, ch_sel_vld = 0, go to IDLE.
  - ch_sel keeps its old value (register files still need it for write-back).
- Latency: request first seen in cycle N (IDLE) → ARB in N+1 → de_start high in N+2 → ch_sel_vld high from N+2.
- Back-to-back: done in cycle M → IDLE in M+1 → next de_start no earlier than M+3.
- Simultaneous terminators (done with err, or done with done_all): treated as a single release.
- Terminator pulses outside BUSY are ignored.
- pause: checked only in IDLE; it never aborts a grant.
- Priority rules:
  - A higher-priority requester arriving during BUSY waits for the release.
  - Among equal priorities, a channel that was just served is picked again only if no other equal-priority candidate exists.
- Channels with index ≥ CH_COUNT do not exist; ch_sel never exceeds CH_COUNT-1.
- de_start and ch_sel_vld are never both low while state is BUSY.

Decomposition:
- Shared defines go in wb_dma_defines.v:
  - state encodings WDMA_SCHED_IDLE/ARB/START/BUSY (2-bit);
  - WDMA_PRI_LSB = 13 and WDMA_PRI_MSB = 15, for extracting ch_pri from CSR.
- One combinational sub-module, wb_dma_rr_pick: inputs are the candidate mask and last_ch; output is the chosen index. Parameterised by CH_COUNT.
- Priority max-reduction and FSM stay in the top module.

Test Plan:
- Reset then vreq = 8'h01, all priorities 0 → ARB, de_start one cycle at N+2, ch_sel = 0; dma_done_all → ch_sel_vld = 0, sched_idle = 1 next cycle.
- vreq = 8'h24, ch_pri[2] = 1, ch_pri[5] = 6 → ch_sel = 5; after its release, with vreq = 8'h04 → ch_sel = 2.
- vreq = 8'h0F, all priorities 3, four release cycles → grant order 0, 1, 2, 3; with the same request held → 0 again (wrap).
- Grant to ch 3, then in BUSY raise ch 7 with priority 7 → ch_sel stays 3 until dma_done; next grant is 7.
- ch_req[4] asserted one cycle, then ch_en[4] cleared in the ARB cycle → no de_start, back to IDLE. Separately, pause = 1 with requests pending → no grant until pause = 0.
- rst low during BUSY (ch_sel = 6) → next cycle IDLE, ch_sel = 0, ch_sel_vld = 0, de_start = 0; dma_err in IDLE → no state change.
